// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared funct3 load codes, writeback FSM encodings and load legality check
package riscv_wb_pkg;
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [0:0] WB_IDLE = 1'b0;
    localparam logic [0:0] WB_WAIT = 1'b1;
    function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] off);
        return !(f3 == FUNCT3_LB || f3 == FUNCT3_LBU ||
                 ((f3 == FUNCT3_LH || f3 == FUNCT3_LHU) && !off[0]) ||
                 (f3 == FUNCT3_LW && off == 2'b00));
    endfunction
endpackage

// File: rtl/riscv_wb_if.sv
// riscv_wb_if: request/acknowledge data-memory read bus
interface riscv_wb_if #(parameter int XLEN = 32);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/riscv_load_align.sv
// riscv_load_align: selects the addressed byte/half/word of a read word and sign/zero-extends it
module riscv_load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word[{off, 3'b000} +: 8];
    assign h = word[{off[1], 4'b0000} +: 16];
    // funct3[2] marks the unsigned variants; funct3[1:0] gives the width
    always_comb
        data = funct3[1:0] == FUNCT3_LB[1:0] ? {{(XLEN-8){b[7] & ~funct3[2]}}, b} :
               funct3[1:0] == FUNCT3_LH[1:0] ? {{(XLEN-16){h[15] & ~funct3[2]}}, h} : word;
endmodule

// File: rtl/riscv_wb.sv
// riscv_wb: writeback/memory stage owning the register file and issuing load reads
module riscv_wb
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] result,
    input  logic            memfetch,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1i,
    input  logic [4:0]      rs2i,
    output logic [XLEN-1:0] rs1v,
    output logic [XLEN-1:0] rs2v,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exception,
    riscv_wb_if.master      mem
);
    logic [0:0]      state;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] load_data;
    logic            accept, bad_load, start_load, ack, w_fire;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_data;

    riscv_load_align #(.XLEN(XLEN)) u_align (
        .word   (mem.rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    // request and stall follow the state directly so an async reset drops them at once
    assign mem.req    = state == WB_WAIT;
    assign mem.addr   = addr_q;
    assign stall      = mem.req;
    assign accept     = state == WB_IDLE && valid_in;
    assign bad_load   = load_illegal(funct3, result[1:0]);
    assign start_load = accept && memfetch && !bad_load;
    assign ack        = mem.req && mem.ack;
    assign w_fire     = (accept && !memfetch) || ack;
    assign w_rd       = ack ? rd_q : rd;
    assign w_data     = w_rd == 5'd0 ? '0 : ack ? load_data : result;
    assign rs1v       = rs1i == 5'd0 ? '0 : regs[rs1i];
    assign rs2v       = rs2i == 5'd0 ? '0 : regs[rs2i];

    // FSM, load context capture and writeback/exception pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WB_IDLE;
            rd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            addr_q    <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exception <= 1'b0;
        end else begin
            wb_valid  <= w_fire;
            exception <= accept && memfetch && bad_load;
            if (w_fire) begin
                wb_rd   <= w_rd;
                wb_data <= w_data;
            end
            if (start_load) begin
                state  <= WB_WAIT;
                rd_q   <= rd;
                f3_q   <= funct3;
                off_q  <= result[1:0];
                addr_q <= {result[XLEN-1:2], 2'b00};
            end else if (ack) begin
                state <= WB_IDLE;
            end
        end
    end

    // register file; entry 0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (w_fire && w_rd != 5'd0) begin
            regs[w_rd] <= w_data;
        end
    end
endmodule

// File: tb/tb_riscv_wb.sv
// tb_riscv_wb: directed self-checking bench for the writeback/memory stage
module tb_riscv_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] result = '0;
    logic        memfetch = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1i = '0;
    logic [4:0]  rs2i = '0;
    logic [31:0] rs1v, rs2v, wb_data;
    logic        stall, wb_valid, exception;
    logic [4:0]  wb_rd;
    int          passed = 0;
    int          total = 0;

    riscv_wb_if #(.XLEN(32)) mem_bus ();

    riscv_wb #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .rd        (rd),
        .result    (result),
        .memfetch  (memfetch),
        .funct3    (funct3),
        .rs1i      (rs1i),
        .rs2i      (rs2i),
        .rs1v      (rs1v),
        .rs2v      (rs2v),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .exception (exception),
        .mem       (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        mem_bus.ack = 1'b0;
        mem_bus.rdata = '0;
        @(negedge clk);
        rs1i = 5'd5;
        rs2i = 5'd31;
        #1;
        total++; if ({stall, mem_bus.req, wb_valid, exception} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {stall, mem_bus.req, wb_valid, exception}); else passed++;
        total++; if ({mem_bus.addr, wb_rd, wb_data} !== 69'd0) $display("FAIL reset_outputs: got addr=%h rd=%0d data=%h expected all 0", mem_bus.addr, wb_rd, wb_data); else passed++;
        total++; if ({rs1v, rs2v} !== 64'd0) $display("FAIL reset_regs: got %h %h expected 0", rs1v, rs2v); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        valid_in = 1'b1; rd = 5'd5; result = 32'd42; memfetch = 1'b0; funct3 = 3'b000;
        rs1i = 5'd5;
        #1;
        total++; if (rs1v !== 32'd0) $display("FAIL no_bypass: got %h expected 0", rs1v); else passed++;
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        total++; if (rs1v !== 32'd42) $display("FAIL alu_reg: got %h expected 0000002a", rs1v); else passed++;
        total++; if ({wb_valid, wb_rd, wb_data, stall} !== {1'b1, 5'd5, 32'd42, 1'b0}) $display("FAIL alu_wb: got v=%b rd=%0d data=%h stall=%b expected v=1 rd=5 data=2a stall=0", wb_valid, wb_rd, wb_data, stall); else passed++;
        @(negedge clk);
        total++; if (wb_valid !== 1'b0) $display("FAIL alu_pulse: got %b expected 0", wb_valid); else passed++;
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        valid_in = 1'b1; rd = 5'd0; result = 32'd7; memfetch = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        rs1i = 5'd0;
        #1;
        total++; if (rs1v !== 32'd0) $display("FAIL rd0_reg: got %h expected 0", rs1v); else passed++;
        total++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd0, 32'd0}) $display("FAIL rd0_wb: got v=%b rd=%0d data=%h expected v=1 rd=0 data=0", wb_valid, wb_rd, wb_data); else passed++;
    endtask

    task automatic test_lb_back_to_back();
        int stall_cycles = 0;
        @(negedge clk);
        valid_in = 1'b1; rd = 5'd6; result = 32'h103; memfetch = 1'b1; funct3 = 3'b000;
        @(negedge clk);
        rd = 5'd7; result = 32'h55; memfetch = 1'b0;
        #1;
        total++; if ({mem_bus.req, stall, mem_bus.addr} !== {2'b11, 32'h100}) $display("FAIL lb_req: got req=%b stall=%b addr=%h expected 1 1 00000100", mem_bus.req, stall, mem_bus.addr); else passed++;
        for (int i = 0; i < 3; i++) begin
            if (stall) stall_cycles++;
            total++; if (wb_valid !== 1'b0) $display("FAIL lb_wait_ignore: got wb_valid=%b expected 0", wb_valid); else passed++;
            if (i == 2) begin
                mem_bus.ack = 1'b1;
                mem_bus.rdata = 32'h80FF_0000;
            end
            @(negedge clk);
        end
        mem_bus.ack = 1'b0;
        if (stall) stall_cycles++;
        total++; if (stall_cycles !== 3) $display("FAIL lb_stall_len: got %0d expected 3", stall_cycles); else passed++;
        rs1i = 5'd6;
        rs2i = 5'd7;
        #1;
        total++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd6, 32'hFFFF_FF80}) $display("FAIL lb_wb: got v=%b rd=%0d data=%h expected v=1 rd=6 data=ffffff80", wb_valid, wb_rd, wb_data); else passed++;
        total++; if ({rs1v, rs2v} !== {32'hFFFF_FF80, 32'd0}) $display("FAIL lb_regs: got %h %h expected ffffff80 00000000", rs1v, rs2v); else passed++;
        total++; if (mem_bus.req !== 1'b0) $display("FAIL lb_req_drop: got %b expected 0", mem_bus.req); else passed++;
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        total++; if ({wb_valid, wb_rd, rs2v} !== {1'b1, 5'd7, 32'h55}) $display("FAIL follower: got v=%b rd=%0d r7=%h expected v=1 rd=7 r7=55", wb_valid, wb_rd, rs2v); else passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s   [5] = '{3'b101, 3'b010, 3'b001, 3'b100, 3'b000};
        logic [31:0] addrs [5] = '{32'h202, 32'h4, 32'h12, 32'h21, 32'h40};
        logic [31:0] datas [5] = '{32'hBEEF_1234, 32'hDEAD_BEEF, 32'h8001_7FFF, 32'h0000_9A00, 32'h0000_00F1};
        logic [31:0] exps  [5] = '{32'h0000_BEEF, 32'hDEAD_BEEF, 32'hFFFF_8001, 32'h0000_009A, 32'hFFFF_FFF1};
        int          lats  [5] = '{1, 2, 1, 4, 1};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_in = 1'b1; rd = 5'(10 + k); result = addrs[k]; memfetch = 1'b1; funct3 = f3s[k];
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            total++; if ({mem_bus.req, mem_bus.addr} !== {1'b1, addrs[k] & 32'hFFFF_FFFC}) $display("FAIL load%0d_req: got req=%b addr=%h", k, mem_bus.req, mem_bus.addr); else passed++;
            for (int j = 1; j < lats[k]; j++) @(negedge clk);
            mem_bus.ack = 1'b1;
            mem_bus.rdata = datas[k];
            @(negedge clk);
            mem_bus.ack = 1'b0;
            mem_bus.rdata = 32'h0BAD_0BAD;
            rs1i = 5'(10 + k);
            #1;
            total++; if ({wb_valid, wb_data, rs1v, stall} !== {1'b1, exps[k], exps[k], 1'b0}) $display("FAIL load%0d_data: got v=%b data=%h reg=%h stall=%b expected data %h", k, wb_valid, wb_data, rs1v, stall, exps[k]); else passed++;
        end
    endtask

    task automatic test_exceptions();
        logic [2:0]  f3s   [4] = '{3'b010, 3'b011, 3'b001, 3'b110};
        logic [31:0] addrs [4] = '{32'h6, 32'h8, 32'h3, 32'h0};
        @(negedge clk);
        valid_in = 1'b1; rd = 5'd9; result = 32'h11; memfetch = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid_in = 1'b1; rd = 5'd9; result = addrs[k]; memfetch = 1'b1; funct3 = f3s[k];
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            total++; if ({exception, mem_bus.req, stall, wb_valid} !== 4'b1000) $display("FAIL exc%0d_flags: got exc/req/stall/wbv=%b expected 1000", k, {exception, mem_bus.req, stall, wb_valid}); else passed++;
            mem_bus.ack = 1'b1;
            mem_bus.rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            mem_bus.ack = 1'b0;
            rs1i = 5'd9;
            #1;
            total++; if ({exception, wb_valid, rs1v} !== {2'b00, 32'h11}) $display("FAIL exc%0d_after: got exc=%b wbv=%b r9=%h expected 0 0 11", k, exception, wb_valid, rs1v); else passed++;
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        valid_in = 1'b1; rd = 5'd20; result = 32'h8; memfetch = 1'b1; funct3 = 3'b010;
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        total++; if (mem_bus.req !== 1'b1) $display("FAIL rstw_req: got %b expected 1", mem_bus.req); else passed++;
        #1 rst = 1'b1;
        #1;
        total++; if ({mem_bus.req, stall} !== 2'b00) $display("FAIL rstw_drop: got req=%b stall=%b expected 0 0", mem_bus.req, stall); else passed++;
        @(negedge clk);
        rst = 1'b0;
        mem_bus.ack = 1'b1;
        mem_bus.rdata = 32'h1234_5678;
        @(negedge clk);
        mem_bus.ack = 1'b0;
        #1;
        total++; if (wb_valid !== 1'b0) $display("FAIL rstw_nowrite: got wb_valid=%b expected 0", wb_valid); else passed++;
        for (int r = 0; r < 32; r++) begin
            rs1i = 5'(r);
            rs2i = 5'(31 - r);
            #1;
            total++; if ({rs1v, rs2v} !== 64'd0) $display("FAIL rstw_reg%0d: got %h %h expected 0", r, rs1v, rs2v); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_rd_zero();
        test_lb_back_to_back();
        test_loads();
        test_exceptions();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/riscv_wb.md
# riscv_wb

Writeback/memory stage closing the IF → ID → EX pipeline: consumes the EX-stage outputs (`result`, `rd`, `memfetch`, `funct3`), owns the 32×32 integer register file, and serves the ID stage's operand reads. Non-load results are written in one cycle. Loads issue a request/acknowledge read to data memory, stall the front end (drives the IF `bubble` input) until the data returns, then sign/zero-extend and write back.

## Interface
- `XLEN`, 32: datapath and register width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  EX output holds a retiring instruction this cycle.
- `rd`  in  5  destination register index.
- `result`  in  XLEN  ALU result; for a load, the effective address.
- `memfetch`  in  1  instruction is a load.
- `funct3`  in  3  load width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- `rs1i`, `rs2i`  in  5 each  ID read-port indices.
- `rs1v`, `rs2v`  out  XLEN each  combinational read data; index 0 always reads 0.
- `stall`  out  1  front end must hold (wired to IF `bubble`).
- `mem_req`  out  1  data-memory read request.
- `mem_addr`  out  XLEN  word-aligned request address (`result` with bits [1:0] cleared).
- `mem_ack`  in  1  `mem_rdata` valid; completes the request.
- `mem_rdata`  in  XLEN  read word.
- `wb_valid`  out  1  one-cycle pulse: a register write happened at the previous edge.
- `wb_rd`  out  5  register written.
- `wb_data`  out  XLEN  value written.
- `exception`  out  1  one-cycle pulse: a load was rejected (misaligned or illegal `funct3`).

## Operation
- FSM states: IDLE, WAIT.
- IDLE, `valid_in` && !`memfetch`: write `regs[rd]` ← `result` if `rd`≠0. Pulse `wb_valid` (also when `rd`=0, with `wb_data`=0).
- IDLE, `valid_in` && `memfetch`, legal and aligned: latch `rd`, `funct3` and `result[1:0]`; set `mem_req`=1 and `mem_addr`; go to WAIT; `stall`=1.
- Illegal load: `funct3` ∈ {011, 110, 111}, LH/LHU with `result[0]`=1, or LW with `result[1:0]`≠0.
  - Pulse `exception`. No request, no write, stay in IDLE.
- WAIT: hold `mem_req`, `mem_addr` and `stall` steady; ignore `valid_in`.
  - On `mem_ack`, extract data:
    - LB/LBU: byte `addr[1:0]`.
    - LH/LHU: half `addr[1]`.
    - LW: the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Write the register (skipped for `rd`=0), pulse `wb_valid`, drop `mem_req` and `stall`, return to IDLE.
- Register file: written at the clock edge. Reads are combinational from the array, with no bypass: a read in the same cycle as a write returns the old value.
- Entry 0 is never written.

## Timing
- Reset (async, immediate): all 32 registers 0, state IDLE. `stall`, `mem_req`, `wb_valid`, `exception` = 0. `mem_addr`, `wb_rd`, `wb_data` = 0.
- Reset during WAIT abandons the load; `mem_req` falls immediately and no write occurs.
- Non-load: `valid_in` sampled at edge N; register and `wb_*` updated at edge N; `wb_valid` high for cycle N+1.
- Load: accepted at edge N; `mem_req`/`stall` high from edge N. `mem_ack` sampled at edge M ≥ N+1 writes the register, clears `mem_req`/`stall`, and `wb_valid` is high for cycle M+1. Minimum latency: 2 cycles.
- `mem_ack` while `mem_req`=0 is ignored.
- Upstream presents the instruction following a load in cycle N+1 and holds it while `stall`=1. It is accepted at the edge where `stall` is sampled 0.
- `exception` is high for exactly the cycle after the rejecting edge.

## Structure
- Shared `riscv/defs.v` gains `FUNCT3_LB`, `FUNCT3_LH`, `FUNCT3_LW`, `FUNCT3_LBU`, `FUNCT3_LHU`, next to the existing `FUNCT3_*`, and state encodings `WB_IDLE`/`WB_WAIT`.
- Sub-module `riscv_load_align`: combinational extract/extend from (`mem_rdata`, `addr[1:0]`, `funct3`), unit-tested separately.

## Test plan
- Reset, then `valid_in`, `rd`=5, `result`=42, `memfetch`=0 → next cycle `rs1i`=5 reads 42, `wb_valid`=1, `wb_rd`=5, `stall`=0.
- Write with `rd`=0, `result`=7 → `rs1i`=0 reads 0; `wb_valid` pulses with `wb_data`=0.
- LB, `result`=0x103, `rd`=6; `mem_ack` 3 cycles later with `mem_rdata`=0x80FF_0000 → `mem_addr`=0x100. `stall` stays 1 for exactly 3 cycles. `regs[6]`=0xFFFF_FF80.
- LHU at 0x202 with `mem_rdata`=0xBEEF_1234 → 0x0000_BEEF; LW at 0x4 with `mem_rdata`=0xDEAD_BEEF → 0xDEAD_BEEF.
- LW at 0x6, and separately `funct3`=011 → `exception` single pulse, `mem_req` stays 0, register unchanged, `stall`=0.
- Load accepted, `rst` asserted in WAIT before `mem_ack` → `mem_req`/`stall` drop immediately. A later `mem_ack` causes no write; all registers read 0.
